// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: debug / ALU / LSU writeback with a
// one-cycle registered write path and a busy scoreboard that drives decode stalls.
module regfile_wb_arbiter #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_wb_valid,
  input  logic [REG_AW-1:0]      alu_wb_addr,
  input  logic [XLEN-1:0]        alu_wb_data,
  output logic                   alu_wb_ready,
  input  logic                   lsu_wb_valid,
  input  logic [REG_AW-1:0]      lsu_wb_addr,
  input  logic [XLEN-1:0]        lsu_wb_data,
  output logic                   lsu_wb_ready,
  input  logic                   dbg_wr_valid,
  input  logic [REG_AW-1:0]      dbg_wr_addr,
  input  logic [XLEN-1:0]        dbg_wr_data,
  output logic                   dbg_wr_ready,
  input  logic                   iss_valid,
  input  logic [REG_AW-1:0]      iss_rd,
  input  logic [REG_AW-1:0]      src1_addr,
  input  logic [REG_AW-1:0]      src2_addr,
  output logic                   hazard_stall,
  output logic                   rf_wr_en,
  output logic [REG_AW-1:0]      rf_addr_wr,
  output logic [XLEN-1:0]        rf_write_port,
  output logic [2**REG_AW-1:0]   busy_vec
);

  localparam int NREG = 2**REG_AW;

  typedef enum logic {RR_ALU = 1'b0, RR_LSU = 1'b1} rr_t;

  rr_t                rr_ptr;
  logic               grant_alu;
  logic               grant_lsu;
  logic               grant_dbg;
  logic               grant_any;
  logic [REG_AW-1:0]  grant_addr;
  logic [XLEN-1:0]    grant_data;
  logic               issue;
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_nxt;
  logic               vld_p1;
  logic [REG_AW-1:0]  addr_p1;
  logic [XLEN-1:0]    data_p1;

  // Debug only gets the port once the pipeline has fully drained.
  always_comb begin
    grant_alu  = alu_wb_valid && (!lsu_wb_valid || (rr_ptr == RR_ALU));
    grant_lsu  = lsu_wb_valid && (!alu_wb_valid || (rr_ptr == RR_LSU));
    grant_dbg  = dbg_wr_valid && !alu_wb_valid && !lsu_wb_valid && (busy_q == '0);
    grant_any  = grant_alu || grant_lsu || grant_dbg;
    grant_addr = '0;
    grant_data = '0;
    if (grant_alu) begin
      grant_addr = alu_wb_addr;
      grant_data = alu_wb_data;
    end else if (grant_lsu) begin
      grant_addr = lsu_wb_addr;
      grant_data = lsu_wb_data;
    end else if (grant_dbg) begin
      grant_addr = dbg_wr_addr;
      grant_data = dbg_wr_data;
    end
  end

  assign alu_wb_ready = grant_alu;
  assign lsu_wb_ready = grant_lsu;
  assign dbg_wr_ready = grant_dbg;

  assign hazard_stall = busy_q[src1_addr] | busy_q[src2_addr] | busy_q[iss_rd] | dbg_wr_valid;
  assign issue        = iss_valid && !hazard_stall && (iss_rd != '0);

  // Set is applied after clear so a newly issued writer keeps its register busy.
  always_comb begin
    busy_nxt = busy_q;
    if (vld_p1) busy_nxt[addr_p1] = 1'b0;
    if (issue)  busy_nxt[iss_rd]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= RR_ALU;
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (grant_alu)      rr_ptr <= RR_LSU;
      else if (grant_lsu) rr_ptr <= RR_ALU;
    end
  end

  // Stage p1: granted write presented to the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= grant_any && (grant_addr != '0);
      if (grant_any) begin
        addr_p1 <= grant_addr;
        data_p1 <= grant_data;
      end
    end
  end

  assign rf_wr_en      = vld_p1;
  assign rf_addr_wr    = addr_p1;
  assign rf_write_port = data_p1;
  assign busy_vec      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random bench for regfile_wb_arbiter against a cycle-level
// model of grants, write-port timing and the busy scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_v, lsu_v, dbg_v, iss_v;
  logic [4:0]  alu_a, lsu_a, dbg_a, iss_rd, src1, src2;
  logic [31:0] alu_d, lsu_d, dbg_d;
  logic        alu_rdy, lsu_rdy, dbg_rdy, stall;
  logic        rf_wr_en;
  logic [4:0]  rf_addr_wr;
  logic [31:0] rf_write_port;
  logic [31:0] busy_vec;

  regfile_wb_arbiter #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_v), .alu_wb_addr(alu_a), .alu_wb_data(alu_d), .alu_wb_ready(alu_rdy),
    .lsu_wb_valid(lsu_v), .lsu_wb_addr(lsu_a), .lsu_wb_data(lsu_d), .lsu_wb_ready(lsu_rdy),
    .dbg_wr_valid(dbg_v), .dbg_wr_addr(dbg_a), .dbg_wr_data(dbg_d), .dbg_wr_ready(dbg_rdy),
    .iss_valid(iss_v), .iss_rd(iss_rd), .src1_addr(src1), .src2_addr(src2),
    .hazard_stall(stall),
    .rf_wr_en(rf_wr_en), .rf_addr_wr(rf_addr_wr), .rf_write_port(rf_write_port),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] busy_m;
  bit          rr_alu;
  bit          en_m;
  logic [4:0]  addr_m;
  logic [31:0] data_m;
  bit          g_alu, g_lsu, g_dbg, stall_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    busy_m = '0;
    rr_alu = 1'b1;
    en_m   = 1'b0;
    addr_m = '0;
    data_m = '0;
  endtask

  // One clock: check combinational outputs, take the edge, check registered outputs.
  task automatic cycle();
    logic [31:0] nb;
    #1;
    stall_m = busy_m[src1] | busy_m[src2] | busy_m[iss_rd] | dbg_v;
    g_alu   = alu_v && (!lsu_v || rr_alu);
    g_lsu   = lsu_v && (!alu_v || !rr_alu);
    g_dbg   = dbg_v && !alu_v && !lsu_v && (busy_m == 0);
    chk("alu_ready", alu_rdy, g_alu);
    chk("lsu_ready", lsu_rdy, g_lsu);
    chk("dbg_ready", dbg_rdy, g_dbg);
    chk("stall", stall, stall_m);
    @(posedge clk);
    #1;
    nb = busy_m;
    if (en_m) nb[addr_m] = 1'b0;
    if (iss_v && !stall_m && iss_rd != 0) nb[iss_rd] = 1'b1;
    busy_m = nb;
    en_m = 1'b0;
    if (g_alu) begin
      en_m = (alu_a != 0); addr_m = alu_a; data_m = alu_d; rr_alu = 1'b0;
    end else if (g_lsu) begin
      en_m = (lsu_a != 0); addr_m = lsu_a; data_m = lsu_d; rr_alu = 1'b1;
    end else if (g_dbg) begin
      en_m = (dbg_a != 0); addr_m = dbg_a; data_m = dbg_d;
    end
    chk("rf_wr_en", rf_wr_en, en_m);
    if (en_m) begin
      chk("rf_addr_wr", rf_addr_wr, addr_m);
      chk("rf_write_port", rf_write_port, data_m);
    end
    chk("busy_vec", busy_vec, busy_m);
  endtask

  function automatic logic [4:0] pick_addr(input bit force_busy);
    int off;
    if ((force_busy || $urandom_range(1, 0) == 1) && busy_m != 0) begin
      off = $urandom_range(31, 0);
      for (int k = 0; k < 32; k++)
        if (busy_m[(off + k) % 32]) return 5'((off + k) % 32);
    end
    return 5'($urandom_range(31, 0));
  endfunction

  logic [4:0] seq [3];
  int         dbg_writes;
  bit         dbg_granted;
  logic [31:0] busy_before;

  initial begin
    rst_n = 1'b0;
    {alu_v, lsu_v, dbg_v, iss_v} = '0;
    {alu_a, lsu_a, dbg_a, iss_rd, src1, src2} = '0;
    {alu_d, lsu_d, dbg_d} = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset rf_wr_en", rf_wr_en, 0);
    chk("reset rf_addr_wr", rf_addr_wr, 0);
    chk("reset rf_write_port", rf_write_port, 0);
    chk("reset busy_vec", busy_vec, 0);
    chk("reset stall", stall, 0);
    model_reset();

    // reset while a grant is pending: the write must be discarded
    alu_v = 1'b1; alu_a = 5'd5; alu_d = 32'h1111;
    #1 chk("midgrant alu_ready", alu_rdy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midgrant rf_wr_en", rf_wr_en, 0);
    chk("midgrant busy_vec", busy_vec, 0);
    rst_n = 1'b1;
    model_reset();

    // contention: ALU x3 vs LSU x4 alternates starting with ALU
    alu_a = 5'd3; alu_d = 32'h33;
    lsu_v = 1'b1; lsu_a = 5'd4; lsu_d = 32'h44;
    for (int i = 0; i < 3; i++) begin
      cycle();
      seq[i] = rf_addr_wr;
    end
    chk("rr seq0", seq[0], 3);
    chk("rr seq1", seq[1], 4);
    chk("rr seq2", seq[2], 3);
    alu_v = 1'b0; lsu_v = 1'b0;
    cycle();

    // ALU alone
    alu_v = 1'b1; alu_a = 5'd5; alu_d = 32'h1234;
    cycle();
    alu_v = 1'b0;
    chk("alu x5 en", rf_wr_en, 1);
    chk("alu x5 addr", rf_addr_wr, 5);
    chk("alu x5 data", rf_write_port, 32'h1234);

    // RAW hazard on x7 until its write lands
    iss_v = 1'b1; iss_rd = 5'd7;
    cycle();
    iss_v = 1'b0; iss_rd = 5'd0; src1 = 5'd7;
    cycle();
    chk("x7 busy", busy_vec[7], 1);
    alu_v = 1'b1; alu_a = 5'd7; alu_d = 32'h77;
    cycle();
    alu_v = 1'b0;
    cycle();
    chk("x7 cleared", busy_vec[7], 0);
    #1 chk("x7 stall released", stall, 0);
    src1 = 5'd0;

    // debug write waits for x9 to drain, then writes x10 exactly once
    iss_v = 1'b1; iss_rd = 5'd9;
    cycle();
    iss_v = 1'b0; iss_rd = 5'd0;
    dbg_v = 1'b1; dbg_a = 5'd10; dbg_d = 32'hDEAD;
    alu_v = 1'b1; alu_a = 5'd9; alu_d = 32'h99;
    cycle();
    alu_v = 1'b0;
    dbg_writes = 0;
    dbg_granted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (rf_wr_en && rf_addr_wr == 5'd10) dbg_writes++;
      if (g_dbg) begin
        dbg_v = 1'b0;
        dbg_granted = 1'b1;
      end
    end
    chk("dbg granted", dbg_granted, 1);
    chk("dbg x10 writes", dbg_writes, 1);

    // write to x0 is accepted but never reaches the register file
    busy_before = busy_m;
    lsu_v = 1'b1; lsu_a = 5'd0; lsu_d = 32'hFFFF;
    cycle();
    lsu_v = 1'b0;
    chk("x0 rf_wr_en", rf_wr_en, 0);
    chk("x0 busy unchanged", busy_vec, busy_before);

    // random traffic, requesters hold until granted
    for (int n = 0; n < 400; n++) begin
      iss_v  = ($urandom_range(2, 0) == 0);
      iss_rd = 5'($urandom_range(31, 0));
      src1   = 5'($urandom_range(31, 0));
      src2   = 5'($urandom_range(31, 0));
      cycle();
      if (!alu_v || g_alu) begin
        alu_v = ($urandom_range(1, 0) == 1) && (!dbg_v || busy_m != 0);
        alu_a = pick_addr(dbg_v);
        alu_d = $urandom;
      end
      if (!lsu_v || g_lsu) begin
        lsu_v = ($urandom_range(1, 0) == 1) && (!dbg_v || busy_m != 0);
        lsu_a = pick_addr(dbg_v);
        lsu_d = $urandom;
      end
      if (!dbg_v || g_dbg) begin
        dbg_v = ($urandom_range(15, 0) == 0);
        dbg_a = 5'($urandom_range(31, 0));
        dbg_d = $urandom;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
